// File: rtl/lsu_pkg.sv
// ============================================================================
// Package : lsu_pkg
// Shared size codes, FSM encoding, latched-op record and alignment check for
// the load/store unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    LD_RESP = 2'd2,
    ST_RMW  = 2'd3
  } lsu_state_e;

  // Only the fields still needed after the accept cycle are kept.
  typedef struct packed {
    logic [1:0]  size;
    logic        sext;
    logic [15:0] wdata;
  } lsu_op_t;

  // Byte is always aligned, half needs an even address, word needs a
  // multiple of four; the reserved size code is never legal.
  function automatic logic lsu_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane.sv
// ============================================================================
// Module  : lsu_lane
// Big-endian lane handling: extract+extend a byte/half from a memory word for
// loads, and merge store data into the old word for read-modify-write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane, then extend it or overwrite it in place.
  always_comb begin
    w_byte   = word_i[31:24];
    w_half   = word_i[31:16];
    ext_o    = word_i;
    merged_o = word_i;

    case (off_i)
      2'd1:    w_byte = word_i[23:16];
      2'd2:    w_byte = word_i[15:8];
      2'd3:    w_byte = word_i[7:0];
      default: w_byte = word_i[31:24];
    endcase
    if (off_i[1]) w_half = word_i[15:0];

    case (size_i)
      SZ_BYTE: begin
        ext_o = {{24{sext_i & w_byte[7]}}, w_byte};
        case (off_i)
          2'd1:    merged_o[23:16] = wdata_i[7:0];
          2'd2:    merged_o[15:8]  = wdata_i[7:0];
          2'd3:    merged_o[7:0]   = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        ext_o = {{16{sext_i & w_half[15]}}, w_half};
        if (off_i[1]) merged_o[15:0]  = wdata_i;
        else          merged_o[31:16] = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module  : lsu_ctrl
// Load/store unit controller: adds byte/half loads and read-modify-write
// stores on top of a word-only, 1-cycle-read data memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  lsu_state_e        state_q, state_d;
  lsu_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        w_aligned;
  logic [31:0] w_ext;
  logic [31:0] w_merged;
  logic        w_unused_addr;

  // Upper address bits are deliberately dropped: addresses wrap at 2**ADDR_W.
  assign w_unused_addr = ^addr[31:ADDR_W];
  assign w_aligned     = lsu_aligned(size, addr[1:0]);
  assign rdata         = rdata_q;

  lsu_lane u_lane (
    .word_i   (mem_dout),
    .wdata_i  (op_q.wdata),
    .off_i    (addr_q[1:0]),
    .size_i   (op_q.size),
    .sext_i   (op_q.sext),
    .ext_o    (w_ext),
    .merged_o (w_merged)
  );

  // State, latched op and load result; reset abandons any op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and all memory/handshake outputs; IDLE outputs are gated by
  // rst so the bus is quiet while reset is asserted.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    stall    = 1'b0;
    done     = 1'b0;
    misalign = 1'b0;
    mem_wr   = 1'b0;
    mem_din  = '0;
    mem_addr = '0;

    case (state_q)
      IDLE: begin
        if (rst && req) begin
          if (!w_aligned) begin
            misalign = 1'b1;
            done     = 1'b1;
          end else begin
            mem_addr = {addr[ADDR_W-1:2], 2'b00};
            if (wr && size == SZ_WORD) begin
              mem_wr  = 1'b1;
              mem_din = wdata;
              done    = 1'b1;
            end else begin
              stall   = 1'b1;
              op_d    = '{size: size, sext: sext, wdata: wdata[15:0]};
              addr_d  = addr[ADDR_W-1:0];
              state_d = wr ? ST_RMW : LD_WAIT;
            end
          end
        end
      end
      LD_WAIT: begin
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        stall    = 1'b1;
        rdata_d  = w_ext;
        state_d  = LD_RESP;
      end
      LD_RESP: begin
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        done     = 1'b1;
        state_d  = IDLE;
      end
      ST_RMW: begin
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wr   = 1'b1;
        mem_din  = w_merged;
        done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module  : tb_lsu_ctrl
// Directed bench for lsu_ctrl paired with a big-endian 1-cycle-read dm model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst, req, wr, sext;
  logic [1:0]        size;
  logic [31:0]       addr, wdata, rdata, mem_din, mem_dout;
  logic              stall, done, misalign, mem_wr;
  logic [ADDR_W-1:0] mem_addr;

  logic [31:0] mem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  int   lat, wr_cnt;
  logic st0, st1, mis;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wr       (wr),
    .size     (size),
    .sext     (sext),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .rdata    (rdata),
    .done     (done),
    .misalign (misalign),
    .mem_addr (mem_addr),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // Data memory: whole-word writes, registered read one cycle after address.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[9:2]] <= mem_din;
    mem_dout <= mem[mem_addr[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, hold req until done; lat = cycles from accept to done
  // (0 = same cycle), st0/st1 = stall in the first two cycles.
  task automatic run_op(input logic wr_, input logic [1:0] size_, input logic sext_,
                        input logic [31:0] addr_, input logic [31:0] wdata_);
    @(negedge clk);
    req = 1'b1; wr = wr_; size = size_; sext = sext_; addr = addr_; wdata = wdata_;
    lat = -1; wr_cnt = 0; st0 = 1'b0; st1 = 1'b0; mis = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mem_wr) wr_cnt++;
      if (c == 0) st0 = stall;
      if (c == 1) st1 = stall;
      if (done) begin
        lat = c;
        mis = misalign;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 32'h0; wdata = 32'h0;

    // Reset state, including a word-store request presented during reset.
    repeat (2) @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hDEADBEEF;
    #1;
    check("rst_stall",    32'(stall),    32'h0);
    check("rst_done",     32'(done),     32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_mem_wr",   32'(mem_wr),   32'h0);
    check("rst_rdata",    rdata,         32'h0);
    check("rst_mem_din",  mem_din,       32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // 1: word store is single-cycle, word load takes 3 cycles inclusive.
    run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    check("sw_lat",   32'(lat),    32'd0);
    check("sw_stall", 32'(st0),    32'd0);
    check("sw_wrcnt", 32'(wr_cnt), 32'd1);
    check("sw_mem",   mem[4],      32'h11223344);
    run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_lat",   32'(lat),    32'd2);
    check("lw_stall", 32'(st0),    32'd1);
    check("lw_wrcnt", 32'(wr_cnt), 32'd0);
    check("lw_rdata", rdata,       32'h11223344);

    // 2: byte store read-modify-write, stall high then low.
    run_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
    check("sb_lat",   32'(lat),    32'd1);
    check("sb_st0",   32'(st0),    32'd1);
    check("sb_st1",   32'(st1),    32'd0);
    check("sb_wrcnt", 32'(wr_cnt), 32'd1);
    check("sb_mem",   mem[4],      32'h1122AA44);

    // 3: halfword store then signed/unsigned halfword loads.
    run_op(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF);
    check("sh_mem", mem[4], 32'hBEEFAA44);
    run_op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    check("lh_rdata", rdata, 32'hFFFFBEEF);
    run_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    check("lhu_rdata", rdata, 32'h0000BEEF);
    run_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("lh_lo_rdata", rdata, 32'hFFFFAA44);

    // 4: byte loads from the last lane, sign and zero extended.
    run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h123456F0);
    run_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lb_rdata", rdata, 32'hFFFFFFF0);
    check("lb_lat",   32'(lat), 32'd2);
    run_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lbu_rdata", rdata, 32'h000000F0);
    run_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check("lb1_rdata", rdata, 32'h00000034);

    // 5: misaligned / illegal ops flag and drop, memory and rdata untouched.
    run_op(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
    check("mis_lw_lat", 32'(lat),    32'd0);
    check("mis_lw_flag", 32'(mis),   32'd1);
    check("mis_lw_st",  32'(st0),    32'd0);
    check("mis_lw_rd",  rdata,       32'h00000034);
    run_op(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000FFFF);
    check("mis_sh_flag",  32'(mis),    32'd1);
    check("mis_sh_wrcnt", 32'(wr_cnt), 32'd0);
    run_op(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF);
    check("mis_sz_flag",  32'(mis),    32'd1);
    check("mis_sz_wrcnt", 32'(wr_cnt), 32'd0);
    check("mis_mem",      mem[4],      32'h123456F0);

    // Address wrap: 0x410 aliases word 0x10.
    run_op(1'b1, 2'b10, 1'b0, 32'h410, 32'hCAFEF00D);
    check("wrap_mem", mem[4], 32'hCAFEF00D);
    run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("wrap_lw", rdata, 32'hCAFEF00D);

    // 6: reset during the ST_RMW write cycle drops the write.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h11; wdata = 32'h55;
    @(posedge clk);
    #1 req = 1'b0;
    check("rmw_wr_pre", 32'(mem_wr), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rmw_wr_rst",   32'(mem_wr), 32'd0);
    check("rmw_done_rst", 32'(done),   32'd0);
    check("rmw_rd_rst",   rdata,       32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("rmw_mem", mem[4], 32'hCAFEF00D);
    run_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check("post_rst_lat", 32'(lat), 32'd2);
    check("post_rst_lb",  rdata,    32'h000000FE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
